// File: rtl/parity_checker_rx_pkg.sv
// Definitions shared by both ends of the parity link: receiver FSM states,
// default word width and the parity-sense encodings.
package parity_pkg;

    localparam int DEFAULT_DATA_W = 32;

    localparam int EVEN = 0;
    localparam int ODD  = 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

endpackage

// File: rtl/parity_checker_rx_if.sv
// Serial bit stream into the parity receiver and the checked word coming back out.
interface parity_checker_rx_if
    import parity_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic              sin;
    logic              sin_valid;
    logic              frame_start;
    logic [DATA_W-1:0] dataout;
    logic              parity_ok;
    logic              out_valid;
    logic              parity_err;

    modport master (
        output sin, sin_valid, frame_start,
        input  dataout, parity_ok, out_valid, parity_err
    );

    modport slave (
        input  sin, sin_valid, frame_start,
        output dataout, parity_ok, out_valid, parity_err
    );

endinterface

// File: rtl/parity_checker_rx.sv
// Receive-side parity checker: reassembles LSB-first serial words, checks the
// trailing parity bit and keeps a saturating count of failed frames.
module parity_checker_rx
    import parity_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ODD_PARITY = EVEN,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_checker_rx_if.slave   rx,
    input  logic                 clr_count,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    localparam int               CNT_W        = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(DATA_W - 1);
    localparam logic             PARITY_SENSE = (ODD_PARITY != 0);

    state_t               state_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [DATA_W-1:0]    shift_q;
    logic [DATA_W-1:0]    dataout_q;
    logic                 run_xor_q;
    logic                 parity_ok_q;
    logic                 out_valid_q;
    logic                 parity_err_q;
    logic                 busy_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    logic start;
    logic parity_bit;
    logic bad_frame;

    // A strobed frame_start restarts reception from any state, so it outranks the parity bit.
    assign start      = rx.sin_valid & rx.frame_start;
    assign parity_bit = rx.sin_valid & ~rx.frame_start & (state_q == PARITY);
    assign bad_frame  = parity_bit & (rx.sin != (run_xor_q ^ PARITY_SENSE));

    // NOTE: always_comb assigns its output first, so no path can leave err_cnt_d unassigned and infer a latch.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_count) begin
            err_cnt_d = '0;
        end else if (bad_frame && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, and every register, including the shift register, has a reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            dataout_q    <= '0;
            run_xor_q    <= 1'b0;
            parity_ok_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            err_cnt_q    <= err_cnt_d;

            if (start) begin
                shift_q   <= DATA_W'(rx.sin);
                run_xor_q <= rx.sin;
                bit_cnt_q <= CNT_W'(1);
                state_q   <= DATA;
                busy_q    <= 1'b1;
            end else if (rx.sin_valid) begin
                case (state_q)
                    DATA: begin
                        shift_q[bit_cnt_q] <= rx.sin;
                        run_xor_q          <= run_xor_q ^ rx.sin;
                        bit_cnt_q          <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        dataout_q    <= shift_q;
                        parity_ok_q  <= ~bad_frame;
                        out_valid_q  <= 1'b1;
                        parity_err_q <= bad_frame;
                        bit_cnt_q    <= '0;
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx.dataout    = dataout_q;
    assign rx.parity_ok  = parity_ok_q;
    assign rx.out_valid  = out_valid_q;
    assign rx.parity_err = parity_err_q;
    assign err_count     = err_cnt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_parity_checker_rx.sv
// Self-checking bench for parity_checker_rx: table-driven frames, hand-written
// corner sequences and random frames scored against a frame-level model.
module tb_parity_checker_rx;
    import parity_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       clr_count;
    logic [7:0] err_a;
    logic [1:0] err_b;
    logic       busy_a;
    logic       busy_b;

    int total = 0;
    int bad   = 0;

    parity_checker_rx_if #(.DATA_W(32)) rx_a ();
    parity_checker_rx_if #(.DATA_W(32)) rx_b ();

    // The narrow-counter instance sees exactly the same bit stream.
    assign rx_b.sin         = rx_a.sin;
    assign rx_b.sin_valid   = rx_a.sin_valid;
    assign rx_b.frame_start = rx_a.frame_start;

    parity_checker_rx #(.DATA_W(32), .ODD_PARITY(EVEN), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx_a),
        .clr_count (clr_count),
        .err_count (err_a),
        .busy      (busy_a)
    );

    parity_checker_rx #(.DATA_W(32), .ODD_PARITY(EVEN), .ERR_CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx_b),
        .clr_count (clr_count),
        .err_count (err_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic        ok;
        logic [7:0]  err_a;
        logic [1:0]  err_b;
    } exp_t;

    typedef struct {
        logic [31:0] value;
        logic        pbit;
        logic        exp_ok;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errs    = 0;
    int   ov_seen = 0;
    logic prev_ov = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic send_bit(input logic b, input logic fs);
        @(negedge clk);
        rx_a.sin         = b;
        rx_a.sin_valid   = 1'b1;
        rx_a.frame_start = fs;
        clr_count        = 1'b0;
    endtask

    // Idle cycles carry junk on sin/frame_start, which must be ignored without a strobe.
    task automatic idle(input int n, input logic chk_busy);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk_busy) check("busy_in_gap", busy_a, 1);
            rx_a.sin         = 1'($urandom_range(0, 1));
            rx_a.sin_valid   = 1'b0;
            rx_a.frame_start = 1'($urandom_range(0, 1));
            clr_count        = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] value, input logic pbit, input logic exp_ok,
                              input int gap_at, input int gap_len, input logic clr_at_parity);
        for (int i = 0; i < 32; i++) begin
            send_bit(value[i], i == 0);
            if (i == gap_at) idle(gap_len, 1'b1);
        end
        send_bit(pbit, 1'b0);
        clr_count = clr_at_parity;
        if (clr_at_parity) errs = 0;
        else if (!exp_ok) errs++;
        exp_q.push_back('{value, exp_ok, 8'(sat(errs, 255)), 2'(sat(errs, 3))});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dataout"},    rx_a.dataout, 0);
        check({tag, "_parity_ok"},  rx_a.parity_ok, 0);
        check({tag, "_out_valid"},  rx_a.out_valid, 0);
        check({tag, "_parity_err"}, rx_a.parity_err, 0);
        check({tag, "_err_count"},  err_a, 0);
        check({tag, "_err_count2"}, err_b, 0);
        check({tag, "_busy"},       busy_a, 0);
    endtask

    // Scoreboard: every out_valid must match the oldest frame the bench completed.
    always @(negedge clk) begin
        if (rx_a.out_valid) begin
            ov_seen++;
            check("ov_one_cycle", prev_ov, 0);
            check("busy_low_at_ov", busy_a, 0);
            if (exp_q.size() == 0) begin
                check("ov_expected", rx_a.out_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("dataout",    rx_a.dataout, mon_e.value);
                check("parity_ok",  rx_a.parity_ok, mon_e.ok);
                check("parity_err", rx_a.parity_err, !mon_e.ok);
                check("err_count",  err_a, mon_e.err_a);
                check("err_count2", err_b, mon_e.err_b);
            end
        end
        if (rx_a.parity_err) check("perr_with_ov", rx_a.out_valid, 1);
        prev_ov = rx_a.out_valid;
    end

    initial begin
        vec_t vecs[7];
        int   sat_tbl[5];
        int   saved_ov;
        logic [7:0] saved_err;
        logic [31:0] rv;
        logic rp;
        int   gap_at;

        vecs[0] = '{32'd0,   1'b0, 1'b1};
        vecs[1] = '{32'd128, 1'b1, 1'b1};
        vecs[2] = '{32'd254, 1'b1, 1'b1};
        vecs[3] = '{32'd439, 1'b1, 1'b1};
        vecs[4] = '{32'd369, 1'b1, 1'b1};
        vecs[5] = '{32'd711, 1'b0, 1'b1};
        vecs[6] = '{32'd369, 1'b0, 1'b0};
        sat_tbl = '{1, 2, 3, 3, 3};

        rst_n            = 1'b0;
        clr_count        = 1'b0;
        rx_a.sin         = 1'b0;
        rx_a.sin_valid   = 1'b0;
        rx_a.frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        idle(2, 1'b0);

        // Good frames back to back, then one with a flipped parity bit.
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].value, vecs[v].pbit, vecs[v].exp_ok, -1, 0, 1'b0);
        end
        idle(2, 1'b0);
        check("table_ov_count", ov_seen, 7);
        check("table_err_count", err_a, 1);

        // Three strobe-free cycles between bits 10 and 11.
        send_frame(32'd254, 1'b1, 1'b1, 10, 3, 1'b0);
        idle(2, 1'b0);

        // Restart after 12 bits: only the second frame produces a result.
        saved_ov  = ov_seen;
        saved_err = err_a;
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), i == 0);
        send_frame(32'd711, 1'b0, 1'b1, -1, 0, 1'b0);
        idle(2, 1'b0);
        check("abort_one_ov", ov_seen - saved_ov, 1);
        check("abort_err_same", err_a, saved_err);

        // Saturation of the 2-bit counter, then clear colliding with an error.
        @(negedge clk);
        clr_count = 1'b1;
        errs      = 0;
        idle(1, 1'b0);
        check("clr_err_count", err_a, 0);
        check("clr_err_count2", err_b, 0);
        for (int k = 0; k < 5; k++) begin
            send_frame(32'd369, 1'b0, 1'b0, -1, 0, 1'b0);
            idle(1, 1'b0);
            check("sat_err_count2", err_b, sat_tbl[k]);
        end
        send_frame(32'd369, 1'b0, 1'b0, -1, 0, 1'b1);
        idle(1, 1'b0);
        check("clr_wins_err_count", err_a, 0);
        check("clr_wins_err_count2", err_b, 0);

        // Reset during bit 20 of a frame.
        for (int i = 0; i <= 20; i++) send_bit(i == 7, i == 0);
        #2 rst_n = 1'b0;
        #1 check_reset_state("midreset");
        errs = 0;
        @(negedge clk);
        rst_n          = 1'b1;
        rx_a.sin_valid = 1'b0;
        send_frame(32'd128, 1'b1, 1'b1, -1, 0, 1'b0);
        idle(2, 1'b0);
        check("post_reset_dataout", rx_a.dataout, 128);
        check("post_reset_parity_ok", rx_a.parity_ok, 1);

        // Random frames, random parity bits, random gaps and spacing.
        for (int n = 0; n < 25; n++) begin
            rv     = $urandom;
            rp     = 1'($urandom_range(0, 1));
            gap_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
            send_frame(rv, rp, rp == (^rv), gap_at, int'($urandom_range(1, 3)), 1'b0);
            idle(int'($urandom_range(0, 2)), 1'b0);
        end

        idle(3, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_checker_rx.md
# parity_checker_rx

Serial receive-side parity checker for the team's 32-bit parity scheme. Bits arrive one per strobe: DATA_W data bits LSB-first, then one parity bit. The block reassembles the word, checks its parity against the received parity bit, and presents the word with a pass/fail result. It sits at the far end of a link whose transmit side appends the parity bit to each word, and it keeps a saturating error count for status reporting.

## Interface
- DATA_W, 32: data bits per frame (≥2).
- ODD_PARITY, 0: 0 = even parity (parity bit = XOR of data bits); 1 = odd (parity bit = XNOR).
- ERR_CNT_W, 8: width of the saturating error counter.

- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- sin  input  1  serial data bit, sampled only when sin_valid=1.
- sin_valid  input  1  bit strobe, one bit per asserted cycle; gaps allowed.
- frame_start  input  1  marks the cycle carrying data bit 0; meaningful only with sin_valid=1.
- clr_count  input  1  synchronous clear of err_count.
- dataout  output  DATA_W  last completed word; holds until the next frame completes.
- parity_ok  output  1  result for dataout; holds with it.
- out_valid  output  1  one-cycle pulse when dataout/parity_ok update.
- parity_err  output  1  one-cycle pulse, coincident with out_valid, when the check fails.
- err_count  output  ERR_CNT_W  failed frames, saturates at all-ones.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- FSM states: IDLE, DATA, PARITY.
- IDLE: when sin_valid & frame_start, shift in bit 0, set bit_cnt=1, and go to DATA. sin_valid without frame_start is ignored.
- DATA: on each sin_valid, place sin at position bit_cnt and XOR it into the running parity. After bit DATA_W-1 is accepted, go to PARITY.
- PARITY: the next sin_valid is the parity bit. Compute expected = running_xor ^ ODD_PARITY. Set ok = (sin == expected). Load dataout and parity_ok, pulse out_valid, and pulse parity_err if !ok. Return to IDLE.
- frame_start & sin_valid in DATA or PARITY aborts the partial frame: it is discarded with no output and no count. That bit becomes bit 0 of a new frame, with bit_cnt=1 and state DATA.
- frame_start without sin_valid is ignored in every state.
- err_count increments by 1 on each parity_err unless it is already all-ones.
- clr_count wins over a simultaneous increment: the result is 0.
- bit_cnt width is clog2(DATA_W). The running parity register resets at each frame start.

## Timing
- Reset values: dataout=0, parity_ok=0, out_valid=0, parity_err=0, err_count=0, busy=0, state=IDLE, bit_cnt=0, running parity=0.
- Reset mid-frame discards the frame with no output.
- Latency: out_valid rises in the cycle after the clock edge that samples the parity bit. All outputs are registered.
- Minimum frame length is DATA_W+1 consecutive strobes. Back-to-back frames need no idle cycle: frame_start can arrive in the cycle right after the parity bit.
- out_valid and parity_err are never asserted for more than one cycle per frame.
- busy rises the cycle after the first bit is accepted. It falls in the same cycle out_valid rises.

## Structure
- Shared package parity_pkg holds:
  - the state enum {IDLE, DATA, PARITY};
  - the DATA_W default (32);
  - the parity-sense localparams EVEN=0 and ODD=1, shared with the transmit side.
- No sub-module is needed: the shift register, counter, XOR accumulator and saturating counter form one module.

## Test plan
- Even parity, frames 0, 128, 254, 439, 369 and 711, each sent with its correct parity bit (0, 1, 1, 1, 1, 0). Required: six out_valid pulses, dataout equal to each value, parity_ok=1, err_count=0.
- Frame 369 sent with parity bit 0. Required: dataout=369, parity_ok=0, a one-cycle parity_err pulse, err_count=1.
- Frame 254 with sin_valid deasserted for 3 cycles between bits 10 and 11. Required: dataout=254, parity_ok=1, busy held high through the gap.
- frame_start re-asserted after 12 bits of a frame, then a full frame 711 with parity 0. Required: exactly one out_valid, dataout=711, err_count unchanged.
- With ERR_CNT_W=2, five bad-parity frames. Required: err_count 1, 2, 3, 3, 3. Then clr_count coinciding with a sixth error gives err_count=0.
- rst_n pulsed low mid-frame, during bit 20. Required: all outputs return to their reset values immediately. The next full frame 128 with parity 1 yields dataout=128 and parity_ok=1.
